// File: rtl/hit_scorer.sv
// hit_scorer
// Judges each light window of the whack-a-light game as a hit, a wrong press
// or a timeout. It keeps the saturating player score and the lives count, and
// flags the game FSM when the lives run out.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-high reset
//   clear         synchronous game restart (loads init_lives, zeroes score)
//   enable        high while the game is in PLAY
//   lives_mode    1 = a wrong press or a timeout costs a life
//   init_lives    lives loaded on clear
//   key_valid     keypad valid-key level, held while the key is down
//   key           keypad key code
//   light_change  light controller change level/strobe
//   light_pos     currently lit position
//   points        player score, saturating
//   lives_left    remaining lives, floored at 0
//   hit_pulse     one-cycle pulse on a correct hit
//   miss_pulse    one-cycle pulse on a wrong press or timeout
//   out_of_lives  sticky flag: lives_mode and lives_left reached 0
module hit_scorer #(
  parameter int POINT_W = 6,
  parameter int LIFE_W  = 4,
  parameter int NUM_POS = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              lives_mode,
  input  logic [LIFE_W-1:0] init_lives,
  input  logic              key_valid,
  input  logic [3:0]        key,
  input  logic              light_change,
  input  logic [3:0]        light_pos,
  output logic [POINT_W-1:0] points,
  output logic [LIFE_W-1:0] lives_left,
  output logic              hit_pulse,
  output logic              miss_pulse,
  output logic              out_of_lives
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] NUM_POS_L = 5'(NUM_POS);

  function automatic logic [POINT_W-1:0] sat_inc(input logic [POINT_W-1:0] v);
    return (v == {POINT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [LIFE_W-1:0] floor_dec(input logic [LIFE_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         target_q, target_d;
  logic [POINT_W-1:0] points_q, points_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               ool_q, ool_d;
  logic               key_prev_q, lc_prev_q;

  logic key_edge, lc_edge, key_ok, key_judge, armed;

  // Rising-edge events; the previous-value registers run every cycle so a key
  // already held when enable rises never produces an edge.
  assign key_edge  = key_valid & ~key_prev_q;
  assign lc_edge   = light_change & ~lc_prev_q;
  assign key_ok    = ({1'b0, key} < NUM_POS_L);
  assign armed     = (state_q == S_ARMED);
  assign key_judge = key_edge & key_ok & armed;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    points_d = points_q;
    lives_d  = lives_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    ool_d    = ool_q;
    if (clear) begin
      points_d = '0;
      lives_d  = init_lives;
      ool_d    = 1'b0;
      state_d  = S_IDLE;
    end else if (!enable) begin
      state_d = S_IDLE;
    end else if (!ool_q) begin
      // A key edge is judged against the old target before any new window
      // opens; a simultaneous wrong press and timeout costs only one miss.
      if (key_judge && (key == target_q)) begin
        hit_d    = 1'b1;
        points_d = sat_inc(points_q);
      end else if (key_judge || (lc_edge && armed)) begin
        miss_d = 1'b1;
        if (lives_mode) lives_d = floor_dec(lives_q);
      end
      if (lc_edge) begin
        state_d  = S_ARMED;
        target_d = light_pos;
      end else if (key_judge) begin
        state_d = S_DONE;
      end
      ool_d = lives_mode && (lives_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      points_q   <= '0;
      lives_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      ool_q      <= 1'b0;
      key_prev_q <= 1'b0;
      lc_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      points_q   <= points_d;
      lives_q    <= lives_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      ool_q      <= ool_d;
      key_prev_q <= key_valid;
      lc_prev_q  <= light_change;
    end
  end

  assign points       = points_q;
  assign lives_left   = lives_q;
  assign hit_pulse    = hit_q;
  assign miss_pulse   = miss_q;
  assign out_of_lives = ool_q;

endmodule

// File: doc/hit_scorer.md
Name: hit_scorer

Overview:
- Sits between the light/keypad controllers and the game top level.
- Consumes the keypad's valid-key level and key code, and the light controller's light position and light-change strobe.
- Judges each light window as hit, wrong press, or timeout; keeps the saturating player score and the lives-remaining count.
- Emits one-cycle hit/miss pulses and a registered out-of-lives flag for the game FSM.

Parameters:
- POINT_W, 6, score counter width; saturates at 2^POINT_W-1.
- LIFE_W, 4, lives counter width.
- NUM_POS, 9, number of valid light/key positions (codes 0..NUM_POS-1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous active-high game restart (driven during RESTART)
- enable  in  1  high while game is in PLAY
- lives_mode  in  1  1 = wrong press/timeout costs a life
- init_lives  in  LIFE_W  lives loaded on clear
- key_valid  in  1  keypad valid-key level (held while key down)
- key  in  4  keypad key code
- light_change  in  1  light controller change level/strobe
- light_pos  in  4  currently lit position
- points  out  POINT_W  player score
- lives_left  out  LIFE_W  remaining lives
- hit_pulse  out  1  one-cycle pulse on a correct hit
- miss_pulse  out  1  one-cycle pulse on a wrong press or timeout
- out_of_lives  out  1  high when lives_mode and lives_left reached 0

Behaviour:
- Async reset: points=0, lives_left=0, hit_pulse=0, miss_pulse=0, out_of_lives=0, window state IDLE, target=0, edge-detect registers=0.
- Edge detection: key_valid and light_change are registered every cycle regardless of enable or clear. Events are rising edges only (current=1, previous=0). A key held across enable rising therefore never scores.
- clear (priority over everything except reset): points=0; lives_left=init_lives; pulses=0; out_of_lives=0; state IDLE.
- Window FSM states:
  - IDLE: no window open. Key edges are ignored.
  - ARMED: window open, not yet judged.
  - DONE: window judged; further key edges are ignored.
- Window open: a light_change edge with enable=1 latches light_pos into target and moves the FSM to ARMED, from any state.
- Key edge while ARMED, key < NUM_POS:
  - key==target: hit_pulse, points+1 (saturating), go to DONE.
  - key!=target: miss_pulse, go to DONE; if lives_mode, lives_left-1.
- Key codes >= NUM_POS are ignored in every state.
- Timeout: a light_change edge while ARMED, with no hit on that same edge, gives miss_pulse and (lives_mode) lives_left-1 before the new window opens.
- Simultaneous key edge and light_change edge: the key is judged against the old target first.
  - Hit: the hit counts; no timeout penalty; new window opens.
  - Wrong press: exactly one miss_pulse and one life lost (not two); new window opens.
- Latency: all outputs are registered on the clock edge that first samples the qualifying input edge, so they are visible one cycle later. Pulses are exactly one cycle wide. hit_pulse and miss_pulse are never both high.
- lives_left never decrements below 0.
- out_of_lives sets on the edge where lives_mode=1 and lives_left becomes (or is) 0. Once set, all events are ignored until clear.
- With lives_mode=0, lives_left holds its cleared value and out_of_lives stays 0.
- enable=0: no judging, no window opens, outputs hold; the FSM returns to IDLE on the first cycle enable is low.
- Reset asserted mid-window: immediate return to the reset values above.

Test Plan:
- Reset, then clear with init_lives=3, enable=1, lives_mode=0; light_change edge with light_pos=4; key_valid edge with key=4 -> next cycle points=1, hit_pulse=1 for one cycle; a second key=4 edge in the same window -> no change.
- lives_mode=1, init_lives=3; window pos=2, press key=5 -> miss_pulse, lives_left=2; then a light_change edge -> no extra loss, new window ARMED.
- lives_mode=1, lives_left=1; window pos=7, no press, light_change edge -> miss_pulse, lives_left=0, out_of_lives=1; subsequent correct presses leave points unchanged.
- Key edge key=3 and light_change edge on the same clock, old target=3 -> points+1, no miss_pulse, target updated to the new light_pos.
- Key held high before enable rises; then a window opens at pos=that key -> no hit until release and re-press; key=12 edge -> ignored.
- POINT_W=6, preload 63 hits via a loop, one more hit -> points stays 63, hit_pulse still fires; assert reset mid-window -> all outputs 0 immediately.
